adc_lane_calib_ctrl: RTL
========================

Name: adc_lane_calib_ctrl

Overview:
- Calibration sequencer that drives the per-lane calibration mux of the ADC receiver.
- Walks the mux select through all lanes. For each lane and for each channel (I, then Q):
  - sweeps IDELAY taps 0..31 against a training pattern;
  - parks the delay at the centre of the widest passing window;
  - issues ISERDES bitslips until the word is aligned.
- Reports per-lane pass/fail to the control logic.

Parameters:
- PORTS, 12: number of lanes behind the mux (1..255).
- TRAIN_PAT, 8'h5A: ADC training word. All 8 rotations must be distinct.
- SETTLE_CYC, 8: wait cycles after any mux, delay or bitslip change (≥4; covers the mux register stage plus the SERDES pipeline).
- SAMPLE_CNT, 16: consecutive words compared per check (≥1).

Ports:
- clk_i, in, 1: system clock.
- rst_n_i, in, 1: reset, asynchronous assert, active-low.
- start_i, in, 1: single-cycle calibration request. Ignored while busy_o=1.
- busy_o, out, 1: calibration in progress.
- done_o, out, 1: one-cycle pulse when the run finishes.
- fail_o, out, 1: sticky for the run; set if any lane or channel failed.
- lane_ok_o, out, PORTS: bit p=1 if both I and Q of lane p calibrated.
- mux_cntrl_o, out, 8: lane select to the mux. 8'hFF = no lane.
- data_serdes_i_i, in, 8: selected I SERDES word from the mux.
- data_serdes_q_i, in, 8: selected Q SERDES word from the mux.
- i_dl_ce_o, out, 1: I IDELAY CE. Always 0.
- i_dl_in_o, out, 1: I IDELAY INC. Always 0.
- i_dl_load_val_o, out, 1: I IDELAY LD pulse.
- i_dl_cnt_in_o, out, 5: I IDELAY CNTVALUEIN.
- i_dl_cnt_val_i, in, 5: I IDELAY CNTVALUEOUT from the mux.
- q_dl_ce_o, out, 1: Q IDELAY CE. Always 0.
- q_dl_in_o, out, 1: Q IDELAY INC. Always 0.
- q_dl_load_val_o, out, 1: Q IDELAY LD pulse.
- q_dl_cnt_in_o, out, 5: Q IDELAY CNTVALUEIN.
- q_dl_cnt_val_i, in, 5: Q IDELAY CNTVALUEOUT from the mux.
- bitslip_i_o, out, 1: I bitslip pulse.
- bitslip_q_o, out, 1: Q bitslip pulse.

Behaviour:
- Reset values: all outputs 0 except mux_cntrl_o=8'hFF. The FSM returns to IDLE immediately (asynchronous), including mid-run. lane_ok_o and fail_o are cleared.
- IDLE:
  - start_i → clear lane_ok_o and fail_o, set busy_o, lane=0, ch=I, go to SEL.
- SEL: mux_cntrl_o<=lane, tap=0, clear the window trackers → LOAD.
- LOAD:
  - Drive cnt_in_o=tap for the current channel; *_load_val_o=1 for exactly 1 cycle.
  - cnt_in_o holds its value until the next LOAD.
  - → SETTLE.
- SETTLE: count SETTLE_CYC cycles → SAMPLE.
- SAMPLE:
  - Compare SAMPLE_CNT consecutive words of the current channel.
  - A word passes if it equals any rotation of TRAIN_PAT.
  - The tap passes only if all words pass.
  - → NEXT_TAP.
- NEXT_TAP, window tracking:
  - Run-length tracking over taps 0..31, linear, no wrap-around.
  - A run replaces the best run only if strictly longer, so the first of equal windows wins.
  - tap<31 → tap+1, LOAD. tap=31 → CENTER.
- CENTER:
  - best_len=0 → load tap 0, mark the channel failed, skip alignment → NEXT_CH.
  - Otherwise centre = best_start + (best_len>>1), computed in 6-bit internally; the result is always ≤31.
  - LOAD the centre, settle → ALIGN_CHK with slips=0.
- ALIGN_CHK:
  - All SAMPLE_CNT words == TRAIN_PAT exactly → channel ok → NEXT_CH.
  - Else if slips==8 → channel failed → NEXT_CH.
  - Else → SLIP.
- SLIP: bitslip for the current channel =1 for 1 cycle, slips+1, settle → ALIGN_CHK.
- NEXT_CH:
  - ch=I → ch=Q, tap=0 → LOAD.
  - ch=Q → lane_ok_o[lane]=I_ok&Q_ok; set fail_o on any failure.
  - lane<PORTS-1 → lane+1, SEL.
  - Else → DONE.
- DONE: mux_cntrl_o=8'hFF, busy_o=0, done_o=1 for one cycle → IDLE.
- Only the active channel's LD and bitslip are ever asserted; the other channel's are held 0.
- mux_cntrl_o is stable for the whole of each lane.

Optional Feature:
- Macro CALIB_TAP_READBACK_EN.
- Defined: after every settle that follows a LOAD, compare the active channel's *_dl_cnt_val_i with the loaded tap.
  - Mismatch → the channel fails immediately: tap 0 loaded, sweep aborted → NEXT_CH.
- Undefined: cnt_val inputs unused; no readback check.

Test Plan:
- Bench model, all lanes pass taps 10..20 and are aligned → each channel's final LD carries 15, zero bitslips, lane_ok_o=12'hFFF, fail_o=0, done_o pulse, mux_cntrl_o returns to 8'hFF.
- Lane 2 I passes taps 2..5 and 20..27 → centre 24 loaded. Lane 2 Q passes taps 4..7 and 12..15 (tie) → centre 6.
- Lane 7 Q word starts 3 rotations from aligned (model rotates by 1 per slip) → exactly 3 bitslip_q_o pulses, 0 bitslip_i_o pulses, lane_ok_o[7]=1.
- Lane 5 I never passes → lane_ok_o[5]=0, fail_o=1, final I load=0, Q of lane 5 still swept, other lanes ok.
- Edge windows: taps 28..31 only → centre 30. Tap 0 only → centre 0. Model never aligns → 8 slips, then channel fail.
- Assert rst_n_i during lane 3 sweep → asynchronous return to reset values; a new start_i completes a full run. With CALIB_TAP_READBACK_EN, the model returns tap+1 on lane 1 → lane_ok_o[1]=0.

Source files
------------

// File: rtl/adc_lane_calib_ctrl.sv
// adc_lane_calib_ctrl: per-lane IDELAY/ISERDES calibration sequencer.
// Steps the receiver mux through every lane. For each lane it handles I, then Q:
// - sweeps the IDELAY taps against the training word;
// - parks the delay at the centre of the widest passing window;
// - bitslips the ISERDES until the word is aligned.
// Optional build macro CALIB_TAP_READBACK_EN: after each settle that follows a
// delay load, the loaded tap is checked against CNTVALUEOUT, and a mismatch
// fails the channel.
module adc_lane_calib_ctrl #(
  parameter int         PORTS      = 12,
  parameter logic [7:0] TRAIN_PAT  = 8'h5A,
  parameter int         SETTLE_CYC = 8,
  parameter int         SAMPLE_CNT = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [PORTS-1:0] lane_ok_o,
  output logic [7:0]       mux_cntrl_o,
  input  logic [7:0]       data_serdes_i_i,
  input  logic [7:0]       data_serdes_q_i,
  output logic             i_dl_ce_o,
  output logic             i_dl_in_o,
  output logic             i_dl_load_val_o,
  output logic [4:0]       i_dl_cnt_in_o,
  input  logic [4:0]       i_dl_cnt_val_i,
  output logic             q_dl_ce_o,
  output logic             q_dl_in_o,
  output logic             q_dl_load_val_o,
  output logic [4:0]       q_dl_cnt_in_o,
  input  logic [4:0]       q_dl_cnt_val_i,
  output logic             bitslip_i_o,
  output logic             bitslip_q_o
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SEL, ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_NEXT_TAP,
    ST_CENTER, ST_ALIGN_CHK, ST_SLIP, ST_NEXT_CH, ST_DONE
  } state_t;

  // What the current settle period is waiting on, so SETTLE knows where to go next.
  typedef enum logic [1:0] {PH_SWEEP, PH_CENTER, PH_SLIP} phase_t;

  localparam logic [PORTS-1:0] LANE_ONE  = PORTS'(1);
  localparam logic [7:0]       LAST_LANE = 8'(PORTS - 1);
  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]      SAMPLE_LAST = 16'(SAMPLE_CNT - 1);

  state_t           state_reg;
  phase_t           phase_reg;
  logic [7:0]       lane_reg;
  logic             ch_q_reg;
  logic [4:0]       tap_reg;
  logic [15:0]      cnt_reg;
  logic             word_ok_reg;
  logic [3:0]       slips_reg;
  logic [5:0]       run_start_reg, run_len_reg, best_start_reg, best_len_reg;
  logic             i_ok_reg, q_ok_reg;
  logic             busy_reg, done_reg, fail_reg;
  logic [PORTS-1:0] lane_ok_reg;
  logic [7:0]       mux_reg;
  logic             i_ld_reg, q_ld_reg, bs_i_reg, bs_q_reg;
  logic [4:0]       i_cnt_reg, q_cnt_reg;

  logic [7:0]       word;
  logic             word_rot, word_exact, readback_bad;
  logic [5:0]       center;
  logic [PORTS-1:0] lane_bit;

  // True when w equals any of the eight rotations of the training word.
  function automatic logic is_rotation(input logic [7:0] w);
    logic [7:0] r;
    logic       hit;
    r   = TRAIN_PAT;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      hit = hit | (w == r);
      r   = {r[6:0], r[7]};
    end
    return hit;
  endfunction

  assign word       = ch_q_reg ? data_serdes_q_i : data_serdes_i_i;
  assign word_rot   = is_rotation(word);
  assign word_exact = (word == TRAIN_PAT);
  assign center     = best_start_reg + {1'b0, best_len_reg[5:1]};
  assign lane_bit   = LANE_ONE << lane_reg;

`ifdef CALIB_TAP_READBACK_EN
  // Delay readback is only meaningful after a load, not after a bitslip.
  assign readback_bad = (phase_reg != PH_SLIP) &&
                        ((ch_q_reg ? q_dl_cnt_val_i : i_dl_cnt_val_i) != tap_reg);
`else
  // Without readback the CNTVALUEOUT inputs are deliberately left unconsumed.
  logic unused_cnt_val;
  assign unused_cnt_val = ^{i_dl_cnt_val_i, q_dl_cnt_val_i};
  assign readback_bad   = 1'b0;
`endif

  // Sequencer: lane/channel walk, tap sweep, window tracking, alignment, results.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= PH_SWEEP;
      lane_reg       <= '0;
      ch_q_reg       <= 1'b0;
      tap_reg        <= '0;
      cnt_reg        <= '0;
      word_ok_reg    <= 1'b0;
      slips_reg      <= '0;
      run_start_reg  <= '0;
      run_len_reg    <= '0;
      best_start_reg <= '0;
      best_len_reg   <= '0;
      i_ok_reg       <= 1'b0;
      q_ok_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      fail_reg       <= 1'b0;
      lane_ok_reg    <= '0;
      mux_reg        <= 8'hFF;
      i_ld_reg       <= 1'b0;
      q_ld_reg       <= 1'b0;
      bs_i_reg       <= 1'b0;
      bs_q_reg       <= 1'b0;
      i_cnt_reg      <= '0;
      q_cnt_reg      <= '0;
    end else begin
      i_ld_reg <= 1'b0;
      q_ld_reg <= 1'b0;
      bs_i_reg <= 1'b0;
      bs_q_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            lane_ok_reg <= '0;
            fail_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            lane_reg    <= '0;
            ch_q_reg    <= 1'b0;
            state_reg   <= ST_SEL;
          end
        end
        ST_SEL: begin
          mux_reg        <= lane_reg;
          tap_reg        <= '0;
          run_start_reg  <= '0;
          run_len_reg    <= '0;
          best_start_reg <= '0;
          best_len_reg   <= '0;
          phase_reg      <= PH_SWEEP;
          state_reg      <= ST_LOAD;
        end
        ST_LOAD: begin
          if (ch_q_reg) begin
            q_ld_reg  <= 1'b1;
            q_cnt_reg <= tap_reg;
          end else begin
            i_ld_reg  <= 1'b1;
            i_cnt_reg <= tap_reg;
          end
          cnt_reg   <= '0;
          state_reg <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg     <= '0;
            word_ok_reg <= 1'b1;
            if (readback_bad) begin
              // Delay did not take the requested tap: park at 0 and give up.
              if (ch_q_reg) begin
                q_ld_reg  <= 1'b1;
                q_cnt_reg <= '0;
                q_ok_reg  <= 1'b0;
              end else begin
                i_ld_reg  <= 1'b1;
                i_cnt_reg <= '0;
                i_ok_reg  <= 1'b0;
              end
              state_reg <= ST_NEXT_CH;
            end else if (phase_reg == PH_SWEEP) begin
              state_reg <= ST_SAMPLE;
            end else begin
              state_reg <= ST_ALIGN_CHK;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_SAMPLE: begin
          word_ok_reg <= word_ok_reg & word_rot;
          if (cnt_reg == SAMPLE_LAST) begin
            state_reg <= ST_NEXT_TAP;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_NEXT_TAP: begin
          // Linear run-length tracking; only a strictly longer run replaces the best.
          if (word_ok_reg) begin
            if (run_len_reg == 6'd0) run_start_reg <= {1'b0, tap_reg};
            run_len_reg <= run_len_reg + 6'd1;
            if (run_len_reg + 6'd1 > best_len_reg) begin
              best_len_reg   <= run_len_reg + 6'd1;
              best_start_reg <= (run_len_reg == 6'd0) ? {1'b0, tap_reg} : run_start_reg;
            end
          end else begin
            run_len_reg <= '0;
          end
          if (tap_reg == 5'd31) begin
            state_reg <= ST_CENTER;
          end else begin
            tap_reg   <= tap_reg + 5'd1;
            state_reg <= ST_LOAD;
          end
        end
        ST_CENTER: begin
          if (best_len_reg == 6'd0) begin
            // No passing tap anywhere: park at 0 and skip alignment.
            if (ch_q_reg) begin
              q_ld_reg  <= 1'b1;
              q_cnt_reg <= '0;
              q_ok_reg  <= 1'b0;
            end else begin
              i_ld_reg  <= 1'b1;
              i_cnt_reg <= '0;
              i_ok_reg  <= 1'b0;
            end
            state_reg <= ST_NEXT_CH;
          end else begin
            tap_reg   <= center[4:0];
            slips_reg <= '0;
            phase_reg <= PH_CENTER;
            state_reg <= ST_LOAD;
          end
        end
        ST_ALIGN_CHK: begin
          word_ok_reg <= word_ok_reg & word_exact;
          if (cnt_reg == SAMPLE_LAST) begin
            cnt_reg <= '0;
            if (word_ok_reg && word_exact) begin
              if (ch_q_reg) q_ok_reg <= 1'b1;
              else          i_ok_reg <= 1'b1;
              state_reg <= ST_NEXT_CH;
            end else if (slips_reg == 4'd8) begin
              if (ch_q_reg) q_ok_reg <= 1'b0;
              else          i_ok_reg <= 1'b0;
              state_reg <= ST_NEXT_CH;
            end else begin
              state_reg <= ST_SLIP;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_SLIP: begin
          if (ch_q_reg) bs_q_reg <= 1'b1;
          else          bs_i_reg <= 1'b1;
          slips_reg <= slips_reg + 4'd1;
          phase_reg <= PH_SLIP;
          cnt_reg   <= '0;
          state_reg <= ST_SETTLE;
        end
        ST_NEXT_CH: begin
          if (!ch_q_reg) begin
            ch_q_reg       <= 1'b1;
            tap_reg        <= '0;
            run_start_reg  <= '0;
            run_len_reg    <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
            phase_reg      <= PH_SWEEP;
            state_reg      <= ST_LOAD;
          end else begin
            if (i_ok_reg && q_ok_reg) lane_ok_reg <= lane_ok_reg | lane_bit;
            else                      fail_reg    <= 1'b1;
            if (lane_reg == LAST_LANE) begin
              state_reg <= ST_DONE;
            end else begin
              lane_reg  <= lane_reg + 8'd1;
              ch_q_reg  <= 1'b0;
              state_reg <= ST_SEL;
            end
          end
        end
        ST_DONE: begin
          mux_reg   <= 8'hFF;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_reg;
  assign done_o          = done_reg;
  assign fail_o          = fail_reg;
  assign lane_ok_o       = lane_ok_reg;
  assign mux_cntrl_o     = mux_reg;
  assign i_dl_ce_o       = 1'b0;
  assign i_dl_in_o       = 1'b0;
  assign i_dl_load_val_o = i_ld_reg;
  assign i_dl_cnt_in_o   = i_cnt_reg;
  assign q_dl_ce_o       = 1'b0;
  assign q_dl_in_o       = 1'b0;
  assign q_dl_load_val_o = q_ld_reg;
  assign q_dl_cnt_in_o   = q_cnt_reg;
  assign bitslip_i_o     = bs_i_reg;
  assign bitslip_q_o     = bs_q_reg;

endmodule
